// File: rtl/gene_net_driver_if.sv
// rtl/gene_net_driver_if.sv - start/status and detector-side bus of the gene network sweep driver
interface gene_net_driver_if #(
   parameter int N         = 8,
   parameter int MAX_STEPS = 16
);
   localparam int SW = $clog2(MAX_STEPS);

   logic          start;
   logic          cycle_flag;
   logic [N-1:0]  init;
   logic [N-1:0]  x;
   logic          x_valid;
   logic [SW-1:0] step_cnt;
   logic          busy;
   logic          done;
   logic          cycle_hit;
   logic          fixpt;
   logic          timeout;

   modport master (
      input  start, cycle_flag,
      output init, x, x_valid, step_cnt, busy, done, cycle_hit, fixpt, timeout
   );

   modport slave (
      output start, cycle_flag,
      input  init, x, x_valid, step_cnt, busy, done, cycle_hit, fixpt, timeout
   );
endinterface

// File: rtl/gene_net_driver.sv
// rtl/gene_net_driver.sv - sweeps all initial states of a threshold Boolean network into the cycle detector
// Optional FIXPT_DETECT_EN ends a trajectory as soon as f(x)==x.
module gene_net_driver #(
   parameter int             N         = 8,
   parameter int             MAX_STEPS = 16,
   parameter logic [N*N-1:0] ACT_MASK  = '0,
   parameter logic [N*N-1:0] INH_MASK  = '0
) (
   input  logic               clk,
   input  logic               rst,
   gene_net_driver_if.master  bus
);
   localparam int SW = $clog2(MAX_STEPS);
   localparam int CW = $clog2(N + 1);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t        state_q, state_d;
   logic [N-1:0]  init_q, init_d;
   logic [N-1:0]  x_q, x_d;
   logic [SW-1:0] step_cnt_q, step_cnt_d;
   logic          busy_q, busy_d;
   logic          x_valid_q, x_valid_d;
   logic          done_q, done_d;
   logic          cycle_hit_q, cycle_hit_d;
   logic          fixpt_q, fixpt_d;
   logic          timeout_q, timeout_d;

   logic [N-1:0]  fx;
   logic [CW-1:0] act_cnt;
   logic [CW-1:0] inh_cnt;
   logic          fixpt_cond;
   logic          last_step;
   logic          end_cond;

   // Threshold update: gene follows the majority of its active regulators, holds on a tie.
   always_comb begin
      fx      = x_q;
      act_cnt = '0;
      inh_cnt = '0;
      for (int i = 0; i < N; i++) begin
         act_cnt = '0;
         inh_cnt = '0;
         for (int j = 0; j < N; j++) begin
            act_cnt = act_cnt + CW'(ACT_MASK[i*N+j] & x_q[j]);
            inh_cnt = inh_cnt + CW'(INH_MASK[i*N+j] & x_q[j]);
         end
         if (act_cnt > inh_cnt) begin
            fx[i] = 1'b1;
         end else if (act_cnt < inh_cnt) begin
            fx[i] = 1'b0;
         end
      end
   end

`ifdef FIXPT_DETECT_EN
   assign fixpt_cond = (fx == x_q);
`else
   assign fixpt_cond = 1'b0;
`endif

   assign last_step = (step_cnt_q == SW'(MAX_STEPS - 1));
   assign end_cond  = bus.cycle_flag | fixpt_cond | last_step;

   always_comb begin
      state_d     = state_q;
      init_d      = init_q;
      x_d         = x_q;
      step_cnt_d  = step_cnt_q;
      busy_d      = busy_q;
      x_valid_d   = x_valid_q;
      done_d      = 1'b0;
      cycle_hit_d = 1'b0;
      fixpt_d     = 1'b0;
      timeout_d   = 1'b0;
      case (state_q)
         IDLE: begin
            if (bus.start) begin
               init_d     = '0;
               x_d        = '0;
               step_cnt_d = '0;
               busy_d     = 1'b1;
               x_valid_d  = 1'b1;
               state_d    = RUN;
            end
         end
         RUN: begin
            if (end_cond) begin
               if (bus.cycle_flag) begin
                  cycle_hit_d = 1'b1;
               end else if (fixpt_cond) begin
                  fixpt_d = 1'b1;
               end else begin
                  timeout_d = 1'b1;
               end
               // The all-ones init is the last trajectory; init never wraps.
               if (init_q == '1) begin
                  x_valid_d = 1'b0;
                  state_d   = DONE;
               end else begin
                  init_d     = init_q + N'(1);
                  x_d        = init_q + N'(1);
                  step_cnt_d = '0;
               end
            end else begin
               x_d        = fx;
               step_cnt_d = step_cnt_q + SW'(1);
            end
         end
         DONE: begin
            done_d    = 1'b1;
            busy_d    = 1'b0;
            x_valid_d = 1'b0;
            state_d   = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= IDLE;
         init_q      <= '0;
         x_q         <= '0;
         step_cnt_q  <= '0;
         busy_q      <= 1'b0;
         x_valid_q   <= 1'b0;
         done_q      <= 1'b0;
         cycle_hit_q <= 1'b0;
         fixpt_q     <= 1'b0;
         timeout_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         init_q      <= init_d;
         x_q         <= x_d;
         step_cnt_q  <= step_cnt_d;
         busy_q      <= busy_d;
         x_valid_q   <= x_valid_d;
         done_q      <= done_d;
         cycle_hit_q <= cycle_hit_d;
         fixpt_q     <= fixpt_d;
         timeout_q   <= timeout_d;
      end
   end

   assign bus.init      = init_q;
   assign bus.x         = x_q;
   assign bus.x_valid   = x_valid_q;
   assign bus.step_cnt  = step_cnt_q;
   assign bus.busy      = busy_q;
   assign bus.done      = done_q;
   assign bus.cycle_hit = cycle_hit_q;
   assign bus.fixpt     = fixpt_q;
   assign bus.timeout   = timeout_q;
endmodule

// File: tb/tb_gene_net_driver.sv
// tb/tb_gene_net_driver.sv - directed bench: zero-mask sweeps, ring network, cycle flag, reset
module tb_gene_net_driver;
   localparam int          N    = 8;
   localparam int          MS   = 16;
   localparam logic [63:0] RING = 64'h4020_1008_0402_0180;
`ifdef FIXPT_DETECT_EN
   localparam bit FIX = 1'b1;
`else
   localparam bit FIX = 1'b0;
`endif

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   int   checks = 0;
   int   errors = 0;

   gene_net_driver_if #(.N(N), .MAX_STEPS(MS)) bus0 ();
   gene_net_driver_if #(.N(N), .MAX_STEPS(MS)) bus1 ();

   gene_net_driver #(.N(N), .MAX_STEPS(MS), .ACT_MASK(64'h0), .INH_MASK(64'h0)) dut0 (
      .clk (clk),
      .rst (rst_n),
      .bus (bus0)
   );

   gene_net_driver #(.N(N), .MAX_STEPS(MS), .ACT_MASK(RING), .INH_MASK(64'h0)) dut1 (
      .clk (clk),
      .rst (rst_n),
      .bus (bus1)
   );

   always #5 clk = ~clk;

   task automatic do_reset();
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      checks++;
      if ({bus0.init, bus0.x, bus0.step_cnt, bus0.busy, bus0.x_valid, bus0.done,
           bus0.cycle_hit, bus0.fixpt, bus0.timeout} !== 26'h0) begin
         errors++;
         $display("FAIL reset_dut0 got init=%h x=%h step=%h busy=%b xv=%b want all 0",
                  bus0.init, bus0.x, bus0.step_cnt, bus0.busy, bus0.x_valid);
      end
      checks++;
      if ({bus1.init, bus1.x, bus1.step_cnt, bus1.busy, bus1.x_valid, bus1.done,
           bus1.cycle_hit, bus1.fixpt, bus1.timeout} !== 26'h0) begin
         errors++;
         $display("FAIL reset_dut1 got init=%h x=%h step=%h busy=%b xv=%b want all 0",
                  bus1.init, bus1.x, bus1.step_cnt, bus1.busy, bus1.x_valid);
      end
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
      checks++;
      if (bus0.busy !== 1'b0 || bus0.x_valid !== 1'b0 || bus0.done !== 1'b0) begin
         errors++;
         $display("FAIL idle_after_reset got busy=%b xv=%b done=%b want 0 0 0",
                  bus0.busy, bus0.x_valid, bus0.done);
      end
   endtask

   task automatic test_zero_sweep(input bit hold);
      int m_state, m_init, m_step, bad, n_fx, n_to, n_ch, done_cyc;
      bit p_fx, p_to, p_done;
      bus0.start = 1'b1;
      @(negedge clk);
      if (!hold) bus0.start = 1'b0;
      checks++;
      if (bus0.busy !== 1'b1 || bus0.x_valid !== 1'b1 || bus0.init !== 8'h00 ||
          bus0.x !== 8'h00 || bus0.step_cnt !== 4'h0) begin
         errors++;
         $display("FAIL sweep_start got busy=%b xv=%b init=%h x=%h step=%h want 1 1 00 00 0",
                  bus0.busy, bus0.x_valid, bus0.init, bus0.x, bus0.step_cnt);
      end
      m_state = 1; m_init = 0; m_step = 0;
      bad = 0; n_fx = 0; n_to = 0; n_ch = 0; done_cyc = -1;
      for (int cyc = 1; cyc <= 5000; cyc++) begin
         p_fx = 1'b0; p_to = 1'b0; p_done = 1'b0;
         if (m_state == 1) begin
            if (FIX || m_step == MS - 1) begin
               p_fx = FIX;
               p_to = !FIX;
               if (m_init == 255) m_state = 2;
               else begin
                  m_init++;
                  m_step = 0;
               end
            end else begin
               m_step++;
            end
         end else if (m_state == 2) begin
            m_state = 0;
            p_done  = 1'b1;
         end
         @(negedge clk);
         if (bus0.init !== 8'(m_init) || bus0.x !== 8'(m_init) || bus0.step_cnt !== 4'(m_step) ||
             bus0.x_valid !== (m_state == 1) || bus0.busy !== (m_state != 0) ||
             bus0.fixpt !== p_fx || bus0.timeout !== p_to || bus0.cycle_hit !== 1'b0 ||
             bus0.done !== p_done) bad++;
         if (bus0.fixpt === 1'b1) n_fx++;
         if (bus0.timeout === 1'b1) n_to++;
         if (bus0.cycle_hit === 1'b1) n_ch++;
         if (bus0.done === 1'b1) begin
            done_cyc = cyc;
            break;
         end
      end
      checks++;
      if (bad !== 0) begin
         errors++;
         $display("FAIL sweep_trace got %0d bad cycles want 0", bad);
      end
      checks++;
      if (n_fx !== (FIX ? 256 : 0) || n_ch !== 0) begin
         errors++;
         $display("FAIL sweep_fixpt_count got %0d (cycle_hit %0d) want %0d", n_fx, n_ch, FIX ? 256 : 0);
      end
      checks++;
      if (n_to !== (FIX ? 0 : 256)) begin
         errors++;
         $display("FAIL sweep_timeout_count got %0d want %0d", n_to, FIX ? 0 : 256);
      end
      checks++;
      if (done_cyc !== (FIX ? 257 : 4097)) begin
         errors++;
         $display("FAIL sweep_done_latency got %0d want %0d", done_cyc, FIX ? 257 : 4097);
      end
      @(negedge clk);
      checks++;
      if (hold) begin
         if (bus0.busy !== 1'b1 || bus0.init !== 8'h00 || bus0.x_valid !== 1'b1) begin
            errors++;
            $display("FAIL held_start_restart got busy=%b init=%h xv=%b want 1 00 1",
                     bus0.busy, bus0.init, bus0.x_valid);
         end
         bus0.start = 1'b0;
      end else begin
         if (bus0.done !== 1'b0 || bus0.busy !== 1'b0 || bus0.init !== 8'hFF || bus0.x !== 8'hFF) begin
            errors++;
            $display("FAIL after_done got done=%b busy=%b init=%h x=%h want 0 0 FF FF",
                     bus0.done, bus0.busy, bus0.init, bus0.x);
         end
      end
   endtask

   task automatic test_ring();
      logic [7:0] seq [16];
      seq = '{8'h01, 8'h03, 8'h07, 8'h0F, 8'h1F, 8'h3F, 8'h7F, 8'hFF,
              8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
      bus1.start = 1'b1;
      @(negedge clk);
      bus1.start = 1'b0;
      for (int k = 0; k < 100; k++) begin
         if (bus1.init === 8'h01) break;
         @(negedge clk);
      end
      checks++;
      if (bus1.init !== 8'h01) begin
         errors++;
         $display("FAIL ring_reach_init1 got init=%h want 01", bus1.init);
      end
      for (int s = 0; s < (FIX ? 8 : 16); s++) begin
         checks++;
         if (bus1.x !== seq[s] || bus1.step_cnt !== 4'(s) || bus1.init !== 8'h01) begin
            errors++;
            $display("FAIL ring_step%0d got x=%h step=%h init=%h want x=%h step=%h init=01",
                     s, bus1.x, bus1.step_cnt, bus1.init, seq[s], 4'(s));
         end
         @(negedge clk);
      end
      checks++;
      if (bus1.fixpt !== FIX || bus1.timeout !== (FIX ? 1'b0 : 1'b1) || bus1.cycle_hit !== 1'b0) begin
         errors++;
         $display("FAIL ring_end_pulse got fixpt=%b timeout=%b cycle_hit=%b want %b %b 0",
                  bus1.fixpt, bus1.timeout, bus1.cycle_hit, FIX, !FIX);
      end
      checks++;
      if (bus1.init !== 8'h02 || bus1.step_cnt !== 4'h0 || bus1.x !== 8'h02) begin
         errors++;
         $display("FAIL ring_next_init got init=%h step=%h x=%h want 02 0 02",
                  bus1.init, bus1.step_cnt, bus1.x);
      end
   endtask

   task automatic test_cycle_flag();
      for (int k = 0; k < 200; k++) begin
         if (bus1.init === 8'h05 && bus1.step_cnt === 4'h3) break;
         @(negedge clk);
      end
      checks++;
      if (bus1.init !== 8'h05 || bus1.step_cnt !== 4'h3 || bus1.x !== 8'h3F) begin
         errors++;
         $display("FAIL cflag_reach got init=%h step=%h x=%h want 05 3 3F",
                  bus1.init, bus1.step_cnt, bus1.x);
      end
      bus1.cycle_flag = 1'b1;
      @(negedge clk);
      bus1.cycle_flag = 1'b0;
      checks++;
      if (bus1.cycle_hit !== 1'b1 || bus1.fixpt !== 1'b0 || bus1.timeout !== 1'b0) begin
         errors++;
         $display("FAIL cflag_pulse got cycle_hit=%b fixpt=%b timeout=%b want 1 0 0",
                  bus1.cycle_hit, bus1.fixpt, bus1.timeout);
      end
      checks++;
      if (bus1.init !== 8'h06 || bus1.x !== 8'h06 || bus1.step_cnt !== 4'h0) begin
         errors++;
         $display("FAIL cflag_next got init=%h x=%h step=%h want 06 06 0",
                  bus1.init, bus1.x, bus1.step_cnt);
      end
      @(negedge clk);
      checks++;
      if (bus1.cycle_hit !== 1'b0) begin
         errors++;
         $display("FAIL cflag_one_cycle got cycle_hit=%b want 0", bus1.cycle_hit);
      end
   endtask

   task automatic test_priority();
      bus0.start = 1'b1;
      @(negedge clk);
      bus0.start = 1'b0;
      for (int k = 0; k < 300; k++) begin
         if (bus0.init === 8'h09 && bus0.step_cnt === (FIX ? 4'h0 : 4'hF)) break;
         @(negedge clk);
      end
      checks++;
      if (bus0.init !== 8'h09 || bus0.step_cnt !== (FIX ? 4'h0 : 4'hF)) begin
         errors++;
         $display("FAIL prio_reach got init=%h step=%h want 09 %h",
                  bus0.init, bus0.step_cnt, FIX ? 4'h0 : 4'hF);
      end
      bus0.cycle_flag = 1'b1;
      @(negedge clk);
      bus0.cycle_flag = 1'b0;
      checks++;
      if (bus0.cycle_hit !== 1'b1 || bus0.fixpt !== 1'b0 || bus0.timeout !== 1'b0) begin
         errors++;
         $display("FAIL prio_pulse got cycle_hit=%b fixpt=%b timeout=%b want 1 0 0",
                  bus0.cycle_hit, bus0.fixpt, bus0.timeout);
      end
      checks++;
      if (bus0.init !== 8'h0A || bus0.x !== 8'h0A || bus0.step_cnt !== 4'h0) begin
         errors++;
         $display("FAIL prio_next got init=%h x=%h step=%h want 0A 0A 0",
                  bus0.init, bus0.x, bus0.step_cnt);
      end
   endtask

   task automatic test_reset_mid_sweep();
      for (int k = 0; k < 2000; k++) begin
         if (bus0.init === 8'h40) break;
         @(negedge clk);
      end
      checks++;
      if (bus0.init !== 8'h40 || bus0.x_valid !== 1'b1) begin
         errors++;
         $display("FAIL mid_reach got init=%h xv=%b want 40 1", bus0.init, bus0.x_valid);
      end
      #2 rst_n = 1'b0;
      #1;
      checks++;
      if ({bus0.init, bus0.x, bus0.step_cnt, bus0.busy, bus0.x_valid, bus0.done,
           bus0.cycle_hit, bus0.fixpt, bus0.timeout} !== 26'h0) begin
         errors++;
         $display("FAIL mid_async_reset got init=%h x=%h step=%h busy=%b xv=%b want all 0",
                  bus0.init, bus0.x, bus0.step_cnt, bus0.busy, bus0.x_valid);
      end
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      repeat (3) @(negedge clk);
      checks++;
      if (bus0.busy !== 1'b0 || bus0.x_valid !== 1'b0 || bus0.init !== 8'h00) begin
         errors++;
         $display("FAIL mid_stays_idle got busy=%b xv=%b init=%h want 0 0 00",
                  bus0.busy, bus0.x_valid, bus0.init);
      end
      bus0.start = 1'b1;
      @(negedge clk);
      bus0.start = 1'b0;
      checks++;
      if (bus0.busy !== 1'b1 || bus0.x_valid !== 1'b1 || bus0.init !== 8'h00 || bus0.step_cnt !== 4'h0) begin
         errors++;
         $display("FAIL mid_restart got busy=%b xv=%b init=%h step=%h want 1 1 00 0",
                  bus0.busy, bus0.x_valid, bus0.init, bus0.step_cnt);
      end
      do_reset();
   endtask

   initial begin
      bus0.start = 1'b0;
      bus0.cycle_flag = 1'b0;
      bus1.start = 1'b0;
      bus1.cycle_flag = 1'b0;
      test_reset();
      test_zero_sweep(1'b0);
      test_ring();
      test_cycle_flag();
      do_reset();
      test_priority();
      test_reset_mid_sweep();
      test_zero_sweep(1'b1);
      do_reset();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/gene_net_driver.md
Name: gene_net_driver

Overview:
- Upstream stage of the gene-network cycle detector.
- Sweeps every initial state 0..2^N-1 of an N-gene threshold Boolean network.
- Per initial state, iterates the network once per clock and drives state x[t+1] plus init onto the detector inputs.
- Ends each trajectory on cycle flag from the detector, on a fixed point, or on a step limit.

Parameters:
- N, 8, number of genes (state width).
- MAX_STEPS, 16, max network updates per initial state before timeout (>=2).
- ACT_MASK, {N*N{1'b0}}, activation matrix; bit [i*N+j]=1 means gene j activates gene i.
- INH_MASK, {N*N{1'b0}}, inhibition matrix; bit [i*N+j]=1 means gene j inhibits gene i.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  reset, active-low, asynchronous.
- start  input  1  begin sweep; sampled only in IDLE.
- cycle_flag  input  1  cycle-detected flag from downstream detector.
- init  output  N  initial state of current trajectory (detector rst input).
- x  output  N  current network state (detector x input).
- x_valid  output  1  high while in RUN.
- step_cnt  output  clog2(MAX_STEPS)  updates done on current init.
- busy  output  1  sweep in progress.
- done  output  1  one-cycle pulse at sweep end.
- cycle_hit  output  1  one-cycle pulse: trajectory ended by cycle_flag.
- fixpt  output  1  one-cycle pulse: trajectory ended by fixed point.
- timeout  output  1  one-cycle pulse: trajectory ended by step limit.

Behaviour:
- Interface: one clock; reset is asynchronous and active-low.
- Reset, including mid-sweep: state=IDLE; all outputs 0; no pulses.
- Update rule, combinational f(x), per gene i:
  - a = popcount(ACT_MASK row i & x); h = popcount(INH_MASK row i & x).
  - Counters are clog2(N+1) bits wide.
  - x_i' = 1 if a>h; 0 if a<h; x_i if a==h.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - On start=1: init<=0, x<=0, step_cnt<=0, busy<=1, go to RUN.
  - start while busy is ignored.
- RUN, each edge, end condition E = cycle_flag | fixpt_cond | (step_cnt==MAX_STEPS-1):
  - fixpt_cond = (f(x)==x), only when FIXPT_DETECT_EN is defined.
  - If E is false: x<=f(x), step_cnt<=step_cnt+1.
  - If E is true: raise exactly one status pulse, priority cycle_hit > fixpt > timeout.
  - If E is true and init==2^N-1: go to DONE.
  - If E is true otherwise: init<=init+1, x<=init+1, step_cnt<=0.
- DONE: done=1 for one cycle, busy<=0, x_valid<=0, return to IDLE; init and x hold last values.
- Init counter has no wrap. The sweep always ends after the all-ones init.
- x_valid=1 exactly in RUN.
- Status pulses last one cycle, coincident with the edge that changes init.

Optional Feature:
- Macro: FIXPT_DETECT_EN.
- Defined: f(x)==x ends the trajectory immediately with a fixpt pulse. The downstream detector ignores steady states, so this is the only way fixed points are reported.
- Undefined: fixpt is tied 0; fixed-point trajectories run until timeout or cycle_flag.

Test Plan:
- Masks all 0, FIXPT_DETECT_EN defined, start pulse -> 256 fixpt pulses, one per init 0..255 on consecutive cycles. done pulses 257 cycles after start is sampled, then busy=0.
- Masks all 0, macro undefined -> every init runs 16 cycles, 256 timeout pulses, done about 4097 cycles after start, fixpt never 1.
- ACT_MASK ring (gene i activated by gene i-1 mod 8), INH_MASK=0, macro defined, observe init=0x01:
  - x sequence 01,03,07,0F,1F,3F,7F,FF.
  - fixpt pulse on the step after FF.
  - Next init=0x02 with step_cnt=0.
- Bench forces cycle_flag=1 for one cycle while init=5, step_cnt=3 -> next cycle cycle_hit=1, init=6, x=6, step_cnt=0. If timeout would also be true on that edge, only cycle_hit pulses.
- rst low for 2 cycles while init=0x40 in RUN -> all outputs 0 asynchronously. After release, start is required to restart from init=0.
- start held high throughout the sweep -> no restart while busy. A new sweep begins only from IDLE, the cycle after done.
